mem_port_arbiter: RTL

- Shares the single 256-bit memory port between the instruction-cache line refill path and the data-cache path (line refill and 32-bit word write).
- Sits between both caches and main memory.
- Owns grant selection (round-robin on contention), the memory request/acknowledge handshake and response routing.
- Provides a timeout watchdog that reports a bus error.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single 256-bit memory port between the instruction-cache
//   refill path and the data-cache path (line refill or 32-bit word write).
//   It selects a grant (round-robin on contention), runs the memory
//   request/ack handshake, routes the returned line to the granted cache,
//   and abandons a transaction with bus_err when mem_ack never arrives.
//
// Ports
//   CLK, RST            clock (rising edge), async active-low reset
//   ic_req/ic_addr      I-cache line read request (level, held until ic_done)
//   ic_line/ic_done     returned line, one-cycle completion pulse
//   dc_req/dc_we/...    D-cache request: line read (dc_we=0) or word write
//   dc_line/dc_done     returned line (reads), one-cycle completion pulse
//   bus_err             pulses with *_done when the transaction timed out
//   mem_*               memory port (request held until ack is sampled)
//   dbg_state           current FSM state, for observation only
//
// Handshakes
//   Requester side: *_req is a level held by the cache until its *_done
//   pulse; the arbiter latches everything it needs on the grant edge, so a
//   request dropped early still completes and still pulses *_done. The
//   cache must drop *_req in the cycle after *_done.
//   Memory side: mem_req and all mem_* outputs stay stable until mem_ack=1
//   is sampled on a rising edge; read data is taken in that same cycle.
//   mem_ack outside an active request is ignored.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [LINE_W-1:0] ic_line,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic [3:0]        dc_wmask,
    output logic [LINE_W-1:0] dc_line,
    output logic              dc_done,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);

    state_t            state, state_d;
    logic              grant_dc, grant_dc_d;   // 1 = DC owns the port
    logic              last_dc, last_dc_d;     // last grant went to DC
    logic [TW-1:0]     timer, timer_d;

    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [3:0]        mem_wmask_d;
    logic [LINE_W-1:0] ic_line_d, dc_line_d;
    logic              ic_done_d, dc_done_d, bus_err_d;

    logic              pick_dc;
    logic              wr_sel;
    logic [ADDR_W-1:0] addr_sel;

    assign dbg_state = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            grant_dc  <= 1'b0;
            last_dc   <= 1'b0;
            timer     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            ic_line   <= '0;
            dc_line   <= '0;
            ic_done   <= 1'b0;
            dc_done   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_d;
            grant_dc  <= grant_dc_d;
            last_dc   <= last_dc_d;
            timer     <= timer_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_wmask <= mem_wmask_d;
            ic_line   <= ic_line_d;
            dc_line   <= dc_line_d;
            ic_done   <= ic_done_d;
            dc_done   <= dc_done_d;
            bus_err   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        grant_dc_d  = grant_dc;
        last_dc_d   = last_dc;
        timer_d     = timer;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wmask_d = mem_wmask;
        ic_line_d   = ic_line;
        dc_line_d   = dc_line;
        ic_done_d   = 1'b0;
        dc_done_d   = 1'b0;
        bus_err_d   = 1'b0;

        // On contention the side that did not win last time gets the port;
        // last_dc resets to 0 (IC), so DC wins the first contended grant.
        pick_dc  = dc_req && (!ic_req || !last_dc);
        wr_sel   = pick_dc && dc_we;
        addr_sel = pick_dc ? dc_addr : ic_addr;

        case (state)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    grant_dc_d  = pick_dc;
                    last_dc_d   = pick_dc;
                    mem_req_d   = 1'b1;
                    mem_we_d    = wr_sel;
                    // Writes are word aligned, reads are line aligned.
                    mem_addr_d  = wr_sel ? (addr_sel & ~ADDR_W'(3))
                                         : (addr_sel & ~ADDR_W'(31));
                    mem_wdata_d = wr_sel ? dc_wdata : '0;
                    mem_wmask_d = wr_sel ? dc_wmask : '0;
                    timer_d     = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                // Ack has priority over a timeout expiring in the same cycle.
                if (mem_ack) begin
                    if (!mem_we) begin
                        if (grant_dc) dc_line_d = mem_rdata;
                        else          ic_line_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    ic_done_d = !grant_dc;
                    dc_done_d = grant_dc;
                    timer_d   = '0;
                    state_d   = S_RESP;
                end else if (WD_EN && (timer == TW'(TIMEOUT - 1))) begin
                    if (grant_dc) dc_line_d = '0;
                    else          ic_line_d = '0;
                    mem_req_d = 1'b0;
                    ic_done_d = !grant_dc;
                    dc_done_d = grant_dc;
                    bus_err_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_RESP;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            S_RESP: begin
                // *_done / bus_err are visible during this cycle and fall
                // back to their 0 defaults on the way out.
                timer_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
